// File: rtl/spi_minion.sv
// rtl/spi_minion.sv - SPI mode-0 minion endpoint with val/rdy word interfaces
module spi_minion #(
  parameter int nbits = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow,
  output logic             underflow
);

  localparam int cw = (nbits > 2) ? $clog2(nbits) : 1;

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic cs_s1, cs_s2, cs_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic mosi_s1, mosi_s2;

  logic [nbits-1:0] tx_sreg, tx_buf;
  logic [nbits-2:0] rx_sreg;
  logic             tx_full;
  // tx_sreg was reloaded at a count wrap and its word/zeros belong to the next frame
  logic             pre_word, pre_zero;
  logic [cw-1:0]    count;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic active, start_cs, abort, bit_rise, bit_fall, frame_done, recv_fire;
  logic [nbits-1:0] word;

  always_ff @(posedge clk) begin
    if (reset) begin
      {cs_s1, cs_s2, cs_h}       <= 3'b000;
      {sclk_s1, sclk_s2, sclk_h} <= 3'b000;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      {cs_s1, cs_s2, cs_h}       <= {cs, cs_s1, cs_s2};
      {sclk_s1, sclk_s2, sclk_h} <= {sclk, sclk_s1, sclk_s2};
      {mosi_s1, mosi_s2}         <= {mosi, mosi_s1};
    end
  end

  assign cs_fall    = cs_h & ~cs_s2;
  assign cs_rise    = ~cs_h & cs_s2;
  assign sclk_rise  = ~sclk_h & sclk_s2;
  assign sclk_fall  = sclk_h & ~sclk_s2;
  assign active     = (state == ACTIVE);
  assign start_cs   = (state == IDLE) && cs_fall;
  assign abort      = active && cs_rise;
  assign bit_rise   = active && !cs_rise && sclk_rise;
  // the fall after the last rise of a frame must not shift the freshly reloaded word
  assign bit_fall   = active && !cs_rise && sclk_fall && (count != '0);
  assign frame_done = bit_rise && (count == cw'(nbits - 1));
  assign word       = {rx_sreg, mosi_s2};
  assign recv_rdy   = !tx_full;
  assign recv_fire  = recv_val && recv_rdy;
  assign miso       = active ? tx_sreg[nbits-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_CS_HIGH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_CS_HIGH: if (cs_s2)   state_next = IDLE;
      IDLE:         if (cs_fall) state_next = ACTIVE;
      ACTIVE:       if (cs_rise) state_next = IDLE;
      default:                   state_next = WAIT_CS_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sreg   <= '0;
      tx_buf    <= '0;
      rx_sreg   <= '0;
      tx_full   <= 1'b0;
      pre_word  <= 1'b0;
      pre_zero  <= 1'b0;
      count     <= '0;
      send_val  <= 1'b0;
      send_msg  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (send_val && send_rdy) send_val <= 1'b0;

      if (start_cs) begin
        count <= '0;
        if (pre_word) begin
          pre_word <= 1'b0;
        end else if (tx_full) begin
          tx_sreg <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          tx_sreg   <= '0;
          underflow <= 1'b1;
        end
      end

      if (abort) begin
        count    <= '0;
        pre_zero <= 1'b0;
      end

      if (bit_fall) tx_sreg <= {tx_sreg[nbits-2:0], 1'b0};

      if (bit_rise) begin
        rx_sreg <= word[nbits-2:0];
        // first rise of a back-to-back frame commits what the wrap preloaded
        if (count == '0) begin
          pre_word <= 1'b0;
          if (pre_zero) begin
            underflow <= 1'b1;
            pre_zero  <= 1'b0;
          end
        end
        if (frame_done) begin
          count <= '0;
          if (!send_val || send_rdy) begin
            send_msg <= word;
            send_val <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
          if (tx_full) begin
            tx_sreg  <= tx_buf;
            tx_full  <= 1'b0;
            pre_word <= 1'b1;
          end else begin
            tx_sreg  <= '0;
            pre_zero <= 1'b1;
          end
        end else begin
          count <= count + 1'b1;
        end
      end

      if (recv_fire) begin
        tx_buf  <= recv_msg;
        tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_minion.sv
// tb/tb_spi_minion.sv - directed self-checking bench for spi_minion
module tb_spi_minion;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso;
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [33:0] recv_msg = '0;
  logic        send_val;
  logic        send_rdy = 1'b0;
  logic [33:0] send_msg;
  logic        overflow, underflow;

  spi_minion #(.nbits(34)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int xfers = 0, uf_cnt = 0, of_cnt = 0;
  logic [33:0] last_msg = '0;
  int uf_at_start;
  logic rdy_at_start;

  // inputs change 1ns after posedge, so negedge sees what the next edge will act on
  always @(negedge clk) begin
    if (send_val && send_rdy) begin
      xfers++;
      last_msg = send_msg;
    end
    if (underflow) uf_cnt++;
    if (overflow) of_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_recv(input logic [33:0] w);
    check("recv_rdy_before_push", recv_rdy, 1);
    recv_val = 1'b1;
    recv_msg = w;
    tick(1);
    recv_val = 1'b0;
    check("recv_rdy_after_push", recv_rdy, 0);
  endtask

  task automatic spi_frame(input logic [33:0] tx, input int nb, input int rst_bit,
                           input bit inj, input logic [33:0] inj_word,
                           output logic [33:0] rx);
    rx = '0;
    mosi = tx[33];
    cs = 1'b0;
    if (inj) begin
      // handshake lands on the same edge that acts on the cs fall
      tick(2);
      recv_val = 1'b1;
      recv_msg = inj_word;
      tick(1);
      recv_val = 1'b0;
      tick(3);
    end else begin
      tick(6);
    end
    uf_at_start = uf_cnt;
    rdy_at_start = recv_rdy;
    for (int i = 0; i < nb; i++) begin
      rx = {rx[32:0], miso};
      sclk = 1'b1;
      tick(6);
      sclk = 1'b0;
      if (i + 1 < nb) mosi = tx[32 - i];
      if (i == rst_bit) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
      end else begin
        tick(6);
      end
    end
    cs = 1'b1;
    tick(6);
  endtask

  initial begin
    logic [33:0] m;
    int x0, u0, o0;

    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_miso", miso, 0);
    check("rst_send_val", send_val, 0);
    check("rst_send_msg", send_msg, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_recv_rdy", recv_rdy, 1);
    tick(5);

    // 1: buffered word goes out on miso, mosi word delivered
    push_recv(34'h2_DEAD_BEEF);
    u0 = uf_cnt;
    spi_frame(34'h1_2345_6789, 34, -1, 1'b0, '0, m);
    check("t1_miso_word", m, 34'h2_DEAD_BEEF);
    check("t1_recv_rdy_at_start", rdy_at_start, 1);
    check("t1_no_underflow", uf_cnt - u0, 0);
    check("t1_send_val", send_val, 1);
    check("t1_send_msg", send_msg, 34'h1_2345_6789);
    send_rdy = 1'b1;
    tick(2);
    check("t1_send_val_drop", send_val, 0);
    check("t1_xfers", xfers, 1);
    check("t1_xfer_msg", last_msg, 34'h1_2345_6789);

    // 2: empty tx buffer
    u0 = uf_cnt;
    x0 = xfers;
    spi_frame(34'h2_5A5A_A5A5, 34, -1, 1'b0, '0, m);
    tick(2);
    check("t2_miso_zero", m, 0);
    check("t2_uf_at_cs_fall", uf_at_start - u0, 1);
    check("t2_uf_once", uf_cnt - u0, 1);
    check("t2_xfers", xfers - x0, 1);
    check("t2_xfer_msg", last_msg, 34'h2_5A5A_A5A5);

    // 3: send side stalled over two frames
    send_rdy = 1'b0;
    x0 = xfers;
    o0 = of_cnt;
    spi_frame(34'h0_1111_2222, 34, -1, 1'b0, '0, m);
    check("t3_of_after_a", of_cnt - o0, 0);
    spi_frame(34'h3_3333_4444, 34, -1, 1'b0, '0, m);
    check("t3_of_after_b", of_cnt - o0, 1);
    check("t3_held_msg", send_msg, 34'h0_1111_2222);
    check("t3_held_val", send_val, 1);
    check("t3_no_xfer_yet", xfers - x0, 0);
    send_rdy = 1'b1;
    tick(2);
    check("t3_val_drop", send_val, 0);
    check("t3_xfer", xfers - x0, 1);
    check("t3_xfer_msg", last_msg, 34'h0_1111_2222);

    // 4: aborted partial frame then full frame
    x0 = xfers;
    spi_frame(34'h3_FFFF_FFFF, 10, -1, 1'b0, '0, m);
    check("t4_partial_no_xfer", xfers - x0, 0);
    spi_frame(34'h0_0000_0001, 34, -1, 1'b0, '0, m);
    tick(2);
    check("t4_one_xfer", xfers - x0, 1);
    check("t4_xfer_msg", last_msg, 34'h0_0000_0001);

    // 5: reset in the middle of a frame
    x0 = xfers;
    spi_frame(34'h1_5555_5555, 34, 17, 1'b0, '0, m);
    tick(2);
    check("t5_aborted_no_xfer", xfers - x0, 0);
    check("t5_send_val", send_val, 0);
    spi_frame(34'h3_FFFF_FFFF, 34, -1, 1'b0, '0, m);
    tick(2);
    check("t5_next_xfer", xfers - x0, 1);
    check("t5_next_msg", last_msg, 34'h3_FFFF_FFFF);

    // 6: recv handshake on the cs-fall detect edge
    u0 = uf_cnt;
    spi_frame(34'h2_0F0F_0F0F, 34, -1, 1'b1, 34'h1_CAFE_F00D, m);
    check("t6_uf", uf_at_start - u0, 1);
    check("t6_buf_held", rdy_at_start, 0);
    check("t6_miso_zero", m, 0);
    check("t6_rdy_after", recv_rdy, 1);
    u0 = uf_cnt;
    spi_frame(34'h0_0000_0000, 34, -1, 1'b0, '0, m);
    check("t6_next_miso", m, 34'h1_CAFE_F00D);
    check("t6_next_no_uf", uf_cnt - u0, 0);
    tick(2);
    check("t6_last_msg", last_msg, 34'h0_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
